// File: rtl/key_toggle_pkg.sv
// rtl/key_toggle_pkg.sv - shared mode encodings for the key/LED bank
package key_toggle_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE    = 2'd0;
    localparam mode_t MODE_FOLLOW    = 2'd1;
    localparam mode_t MODE_SET_LATCH = 2'd2;

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-FF sync, counter debounce, press/release strobes
module key_debounce_ch #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic stable,
    output logic press,
    output logic released,
    output logic accept_rise,
    output logic accept_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Accept decision is exported combinationally so the LED can change on the same edge as stable.
    assign accept      = (sync2 != stable) && (cnt == CNT_LAST);
    assign accept_rise = accept & sync2;
    assign accept_fall = accept & ~sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1    <= key_in;
            sync2    <= sync1;
            press    <= accept_rise;
            released <= accept_fall;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_toggle_bank.sv
// rtl/key_toggle_bank.sv - N_CH debounced keys driving LEDs in toggle, follow or set-latch mode
module key_toggle_bank
    import key_toggle_pkg::*;
#(
    parameter int    N_CH         = 4,
    parameter int    DEBOUNCE_CYC = 4,
    parameter int    CNT_W        = $clog2(DEBOUNCE_CYC + 1),
    parameter bit    KEY_POL      = 1'b1,
    parameter mode_t MODE         = MODE_TOGGLE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] key,
    input  logic            clr,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] released
);

    logic [N_CH-1:0] key_norm;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    // Internally 1 always means pressed, whatever the board wiring.
    assign key_norm = KEY_POL ? key : ~key;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .key_in     (key_norm[g]),
            .stable     (stable[g]),
            .press      (press[g]),
            .released   (released[g]),
            .accept_rise(rise[g]),
            .accept_fall(fall[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else begin
            case (MODE)
                MODE_FOLLOW:    led <= (stable & ~fall) | rise;
                MODE_SET_LATCH: led <= clr ? '0 : (led | rise);
                default:        led <= clr ? '0 : (led ^ rise);
            endcase
        end
    end

endmodule

// File: tb/tb_key_toggle_bank.sv
// tb/tb_key_toggle_bank.sv - four DUT variants against a sample-history reference model
module tb_key_toggle_bank;
    import key_toggle_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] key_raw = 4'h0;
    logic [3:0] key_inv;
    logic [3:0] led_o [4];
    logic [3:0] press_o [4];
    logic [3:0] rel_o [4];

    int n_assert = 0;
    int n_fail = 0;

    // Per-variant parameters: 0 toggle, 1 follow, 2 set-latch, 3 active-low key with 1-cycle debounce
    int deb [4] = '{4, 4, 4, 1};
    int mode [4] = '{0, 1, 2, 0};

    logic [3:0] m_stable [4];
    logic [3:0] m_led [4];
    logic [3:0] m_press [4];
    logic [3:0] m_rel [4];
    logic [3:0] hist [4][8];

    always #5 clk = ~clk;
    assign key_inv = ~key_raw;

    key_toggle_bank #(.N_CH(4), .DEBOUNCE_CYC(4), .KEY_POL(1'b1), .MODE(MODE_TOGGLE)) dut0 (
        .clk(clk), .reset(reset), .key(key_raw), .clr(clr),
        .led(led_o[0]), .press(press_o[0]), .released(rel_o[0]));
    key_toggle_bank #(.N_CH(4), .DEBOUNCE_CYC(4), .KEY_POL(1'b1), .MODE(MODE_FOLLOW)) dut1 (
        .clk(clk), .reset(reset), .key(key_raw), .clr(clr),
        .led(led_o[1]), .press(press_o[1]), .released(rel_o[1]));
    key_toggle_bank #(.N_CH(4), .DEBOUNCE_CYC(4), .KEY_POL(1'b1), .MODE(MODE_SET_LATCH)) dut2 (
        .clk(clk), .reset(reset), .key(key_raw), .clr(clr),
        .led(led_o[2]), .press(press_o[2]), .released(rel_o[2]));
    key_toggle_bank #(.N_CH(4), .DEBOUNCE_CYC(1), .KEY_POL(1'b0), .MODE(MODE_TOGGLE)) dut3 (
        .clk(clk), .reset(reset), .key(key_inv), .clr(clr),
        .led(led_o[3]), .press(press_o[3]), .released(rel_o[3]));

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_stable[i] = '0;
            m_led[i]    = '0;
            m_press[i]  = '0;
            m_rel[i]    = '0;
            for (int h = 0; h < 8; h++) hist[i][h] = '0;
        end
    endtask

    // A level is accepted once the synchronised samples 2..DEBOUNCE_CYC+1 edges old all disagree with stable.
    task automatic model_edge();
        logic [3:0] rise, fall;
        bit acc;
        for (int i = 0; i < 4; i++) begin
            for (int h = 7; h > 0; h--) hist[i][h] = hist[i][h-1];
            hist[i][0] = key_raw;
            rise = '0;
            fall = '0;
            for (int c = 0; c < 4; c++) begin
                acc = 1'b1;
                for (int j = 2; j <= deb[i] + 1; j++)
                    if (hist[i][j][c] == m_stable[i][c]) acc = 1'b0;
                if (acc) begin
                    if (m_stable[i][c]) fall[c] = 1'b1;
                    else rise[c] = 1'b1;
                    m_stable[i][c] = ~m_stable[i][c];
                end
            end
            m_press[i] = rise;
            m_rel[i]   = fall;
            case (mode[i])
                1:       m_led[i] = m_stable[i];
                2:       m_led[i] = clr ? 4'h0 : (m_led[i] | rise);
                default: m_led[i] = clr ? 4'h0 : (m_led[i] ^ rise);
            endcase
        end
    endtask

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s dut%0d led", tag, i), led_o[i], m_led[i]);
            check_val($sformatf("%s dut%0d press", tag, i), press_o[i], m_press[i]);
            check_val($sformatf("%s dut%0d release", tag, i), rel_o[i], m_rel[i]);
        end
    endtask

    // Called just after a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic [3:0] k, input logic c);
        key_raw = k;
        clr     = c;
        @(posedge clk);
        if (reset) model_edge();
        else model_reset();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] k;
        model_reset();
        @(negedge clk);

        // Reset held with all keys pressed; outputs stay 0.
        step("in_reset", 4'hF, 1'b0);
        step("in_reset", 4'hF, 1'b0);
        reset = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step("post_reset", 4'hF, 1'b0);
            if (e == 2) check_val("pol0_deb1 press E2", press_o[3], 4'hF);
            if (e == 4) check_val("toggle press E4", press_o[0], 4'h0);
            if (e == 5) begin
                check_val("toggle press E5", press_o[0], 4'hF);
                check_val("toggle led E5", led_o[0], 4'hF);
            end
        end
        for (int e = 0; e < 8; e++) step("release_all", 4'h0, 1'b0);
        check_val("toggle led kept after release", led_o[0], 4'hF);

        step("clr_alone", 4'h0, 1'b1);
        check_val("clr alone led", led_o[0], 4'h0);

        // Clean press on ch0 twice: toggles on, then off.
        for (int r = 0; r < 2; r++) begin
            for (int e = 0; e < 10; e++) step("ch0_press", 4'h1, 1'b0);
            for (int e = 0; e < 8; e++) step("ch0_release", 4'h0, 1'b0);
        end
        check_val("ch0 second press led", led_o[0], 4'h0);

        // Glitch train on ch1: 3 high, 1 low, four times.
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 3; e++) step("glitch", 4'h2, 1'b0);
            step("glitch", 4'h0, 1'b0);
        end
        for (int e = 0; e < 6; e++) step("glitch_tail", 4'h0, 1'b0);
        check_val("glitch led", led_o[0], 4'h0);

        // Press on ch2 with clr on the accept edge (E5).
        for (int e = 0; e <= 5; e++) step("clr_prio", 4'h4, (e == 5));
        check_val("clr_prio press", press_o[0], 4'h4);
        check_val("clr_prio led", led_o[0], 4'h0);
        for (int e = 0; e < 8; e++) step("clr_prio_rel", 4'h0, 1'b0);

        // Reset mid-count with keys held, then fresh press after full latency.
        step("midcnt", 4'hF, 1'b0);
        step("midcnt", 4'hF, 1'b0);
        step("midcnt", 4'hF, 1'b0);
        async_reset("midcnt_rst");
        for (int e = 0; e < 8; e++) step("midcnt_after", 4'hF, 1'b0);

        // Randomised phase across all variants.
        k = 4'h0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) k[c] = ~k[c];
            step("random", k, ($urandom_range(0, 19) == 0));
            if (cyc == 300) async_reset("random_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
